// File: rtl/bram_bus_bridge_rv32_if.sv
// bram_bus_bridge_rv32_if: CPU request/response bundle plus the BRAM port and
// error flag of the bridge. The master side is the environment (CPU + BRAM);
// the slave side is the bridge itself.
interface bram_bus_bridge_rv32_if #(
    parameter int unsigned data_width    = 32,
    parameter int unsigned address_width = 32
);
    logic                     mem_valid;
    logic [address_width-1:0] mem_addr;
    logic [data_width-1:0]    mem_wdata;
    logic [3:0]               mem_wstrb;
    logic                     mem_ready;
    logic [data_width-1:0]    mem_rdata;
    logic [address_width-1:0] ram_addr;
    logic [3:0]               ram_wr;
    logic [data_width-1:0]    ram_din;
    logic [data_width-1:0]    ram_dout;
    logic                     err;
    logic                     err_clr;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb, ram_dout, err_clr,
        input  mem_ready, mem_rdata, ram_addr, ram_wr, ram_din, err
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb, ram_dout, err_clr,
        output mem_ready, mem_rdata, ram_addr, ram_wr, ram_din, err
    );
endinterface

// File: rtl/bram_bus_bridge_rv32.sv
// bram_bus_bridge_rv32: bridges a PicoRV32-style valid/ready memory bus onto a
// single-port BRAM with one cycle of read latency. Requests inside
// [BaseAddress, EndAddress] take four states (IDLE->ISSUE->CAPTURE->DONE);
// requests outside the window skip the BRAM and complete from IDLE->DONE.
// Optional feature macro: BRAM_BRIDGE_ERR_EN enables the sticky out-of-range
// err flag (cleared by err_clr, set wins). Without it err is tied to 0.
module bram_bus_bridge_rv32 #(
    parameter logic [63:0] BaseAddress   = 64'h0,
    parameter logic [63:0] EndAddress    = 64'h0,
    parameter int unsigned data_width    = 32,
    parameter int unsigned address_width = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    bram_bus_bridge_rv32_if.slave   io_bus
);

    localparam int unsigned AW = address_width;
    localparam int unsigned DW = data_width;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } state_t;

    state_t          r_state;
    logic            r_mem_ready;
    logic [DW-1:0]   r_mem_rdata;
    logic [AW-1:0]   r_ram_addr;
    logic [3:0]      r_ram_wr;
    logic [DW-1:0]   r_ram_din;
    logic            r_is_read;

    logic [AW-1:0]   w_base;
    logic [AW-1:0]   w_end;
    logic            w_in_range;
    logic            w_accept_oor;

    // Window bounds as nets so the unsigned compare stays full-width.
    assign w_base       = AW'(BaseAddress);
    assign w_end        = AW'(EndAddress);
    assign w_in_range   = (io_bus.mem_addr >= w_base) && (io_bus.mem_addr <= w_end);
    assign w_accept_oor = (r_state == IDLE) && io_bus.mem_valid && !w_in_range;

    // Transaction FSM with all bus and BRAM outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_mem_ready <= 1'b0;
            r_mem_rdata <= '0;
            r_ram_addr  <= '0;
            r_ram_wr    <= 4'h0;
            r_ram_din   <= '0;
            r_is_read   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.mem_valid) begin
                        if (w_in_range) begin
                            r_ram_addr <= io_bus.mem_addr;
                            r_ram_din  <= io_bus.mem_wdata;
                            r_ram_wr   <= io_bus.mem_wstrb;
                            r_is_read  <= (io_bus.mem_wstrb == 4'h0);
                            r_state    <= ISSUE;
                        end else begin
                            r_mem_rdata <= '0;
                            r_mem_ready <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    r_ram_wr <= 4'h0;
                    r_state  <= CAPTURE;
                end
                CAPTURE: begin
                    r_mem_rdata <= r_is_read ? io_bus.ram_dout : '0;
                    r_mem_ready <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    r_mem_ready <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign io_bus.mem_ready = r_mem_ready;
    assign io_bus.mem_rdata = r_mem_rdata;
    assign io_bus.ram_addr  = r_ram_addr;
    assign io_bus.ram_wr    = r_ram_wr;
    assign io_bus.ram_din   = r_ram_din;

`ifdef BRAM_BRIDGE_ERR_EN
    logic r_err;

    // Sticky out-of-range flag; a new violation outranks a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_accept_oor) begin
            r_err <= 1'b1;
        end else if (io_bus.err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign io_bus.err = r_err;
`else
    logic w_unused_err;

    // Error reporting compiled out: flag tied low, clear input ignored.
    assign w_unused_err = io_bus.err_clr ^ w_accept_oor;
    assign io_bus.err   = 1'b0;
`endif

endmodule
